bip2_control_unit: RTL and testbench
====================================

// Module: bip2_control_unit
// PURPOSE
//   Multi-cycle FSM that sequences the BIP-2 datapath: fetch, decode, execute, writeback.
//   Owns PC, IR and the latched Z/N flags. Drives the 11-bit add/sub ALU's operation select,
//   the accumulator write/source selects and the data-memory strobes. Resolves conditional
//   branches from the ALU z/n outputs.
// PARAMETERS
//   ADDR_W  11  PC / data address / operand width; matches ALU width
//   OPC_W   5   opcode field width; instruction word = OPC_W+ADDR_W = 16 bits
// PORTS
//   clk              in   1       single clock, rising edge
//   rst              in   1       synchronous, active-high reset
//   instr_addr_o     out  ADDR_W  instruction address (= PC)
//   instr_rd_o       out  1       instruction read strobe
//   instr_data_i     in   16      instruction word, valid the cycle after instr_rd_o
//   data_addr_o      out  ADDR_W  data address (= IR operand)
//   data_rd_o        out  1       data read strobe; data valid next cycle in datapath
//   data_wr_o        out  1       data write strobe (writes accumulator)
//   operand_o        out  ADDR_W  IR operand field (immediate / branch target)
//   alu_operation_o  out  1       0 = add, 1 = sub
//   alu_src_imm_o    out  1       ALU operand2: 1 = operand_o, 0 = data memory
//   acc_src_o        out  2       0 = ALU result, 1 = data memory, 2 = operand_o
//   acc_wr_o         out  1       accumulator write enable
//   alu_z_i, alu_n_i in   1       ALU zero / negative flags
//   halted_o         out  1       high in HALT
//   instr_ready_i, data_ready_i  in  1  present only with BIP2_MEM_WAIT_EN
// BEHAVIOUR
//   Reset: state FETCH, PC=0, IR=0, Z=N=0; every strobe, acc_wr_o and halted_o = 0.
//     Reset mid-instruction aborts it; no write commits in the reset cycle.
//   FETCH: instr_rd_o=1, instr_addr_o=PC -> DECODE.
//   DECODE: IR <= instr_data_i; PC <= PC+1 (mod 2^ADDR_W; 0x7FF wraps to 0) -> EXECUTE.
//   EXECUTE, by opcode (hex):
//     HLT 00    -> HALT
//     STO 01    data_wr_o=1 -> FETCH
//     LD 02, ADD 04, SUB 06    data_rd_o=1 -> WRITEBACK
//     LDI 03, ADDI 05, SUBI 07 -> WRITEBACK
//     BEQ 08: Z; BNE 09: !Z; BGT 0A: !Z&!N; BGE 0B: !N; BLT 0C: N; BLE 0D: N|Z
//       condition true -> PC <= operand; -> FETCH either way
//     JMP 0E    PC <= operand -> FETCH
//     other     NOP -> FETCH
//   WRITEBACK: acc_wr_o=1 with acc_src_o per op; alu_operation_o=1 for SUB/SUBI, else 0.
//     ADD/ADDI/SUB/SUBI only: Z<=alu_z_i, N<=alu_n_i. LD/LDI leave flags unchanged.
//     -> FETCH
//   HALT: halted_o=1; no strobes; stays until rst.
//   CPI: 4 cycles for ALU/load ops, 3 for STO, branches, JMP and NOP.
//   Branches read only latched flags, never live alu_z_i/alu_n_i.
//   Select outputs hold their decoded value from EXECUTE through WRITEBACK.
//   Strobes are one cycle and mutually exclusive.
// CONFIGURATION
//   BIP2_MEM_WAIT_EN defined:
//     FETCH holds until instr_ready_i=1; the EXECUTE of LD/ADD/SUB/STO holds until
//     data_ready_i=1. Strobes and addresses stay asserted while held.
//     IR captures instr_data_i in the cycle after ready.
//   Undefined: ready ports absent; memories are fixed one-cycle latency.
// STRUCTURE
//   Package bip2_pkg: opcode localparams, state encoding (FETCH, DECODE, EXECUTE,
//     WRITEBACK, HALT), acc_src encodings, ADDR_W/OPC_W constants.
//   Sub-module bip2_decoder: combinational opcode -> control-word decode
//     (alu op, src selects, mem strobes, branch condition code).
// TESTING
//   1. rst held 2 cycles, then release -> instr_addr_o=0x000 with instr_rd_o=1 on the
//      first cycle after release; all other outputs 0.
//   2. LDI 5; ADDI 3; SUBI 8 -> acc_wr_o pulses at cycles 4, 8, 12;
//      alu_operation_o=1 on the SUBI writeback; Z=1, N=0 after SUBI (ALU model returns 0).
//   3. SUBI giving 0x7FF (N=1), then BLT 0x040 -> next instr_addr_o=0x040;
//      same sequence with BGE -> PC falls through to next address.
//   4. PC=0x7FF executing NOP -> following fetch at 0x000 (wrap).
//   5. HLT -> halted_o=1 and no strobes for 20 cycles;
//      rst pulse -> fetch from 0x000, halted_o=0.
//   6. BIP2_MEM_WAIT_EN: instr_ready_i low 3 cycles during FETCH -> instr_rd_o held 4 cycles;
//      LD with data_ready_i delayed 2 cycles -> acc_wr_o pulses once, after ready.

Source files
------------

// File: rtl/bip2_pkg.sv
// bip2_pkg: shared definitions for the BIP-2 control unit.
//   - datapath / opcode widths
//   - FSM state encoding
//   - opcode values, accumulator-source and branch-condition encodings
//   - decoded control word and the branch-condition evaluator
package bip2_pkg;

   localparam int BIP2_ADDR_W  = 11;
   localparam int BIP2_OPC_W   = 5;
   localparam int BIP2_INSTR_W = BIP2_OPC_W + BIP2_ADDR_W;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_WRITEBACK = 3'd3,
      ST_HALT      = 3'd4
   } state_t;

   localparam logic [BIP2_OPC_W-1:0] OP_HLT  = 5'h00;
   localparam logic [BIP2_OPC_W-1:0] OP_STO  = 5'h01;
   localparam logic [BIP2_OPC_W-1:0] OP_LD   = 5'h02;
   localparam logic [BIP2_OPC_W-1:0] OP_LDI  = 5'h03;
   localparam logic [BIP2_OPC_W-1:0] OP_ADD  = 5'h04;
   localparam logic [BIP2_OPC_W-1:0] OP_ADDI = 5'h05;
   localparam logic [BIP2_OPC_W-1:0] OP_SUB  = 5'h06;
   localparam logic [BIP2_OPC_W-1:0] OP_SUBI = 5'h07;
   localparam logic [BIP2_OPC_W-1:0] OP_BEQ  = 5'h08;
   localparam logic [BIP2_OPC_W-1:0] OP_BNE  = 5'h09;
   localparam logic [BIP2_OPC_W-1:0] OP_BGT  = 5'h0A;
   localparam logic [BIP2_OPC_W-1:0] OP_BGE  = 5'h0B;
   localparam logic [BIP2_OPC_W-1:0] OP_BLT  = 5'h0C;
   localparam logic [BIP2_OPC_W-1:0] OP_BLE  = 5'h0D;
   localparam logic [BIP2_OPC_W-1:0] OP_JMP  = 5'h0E;

   localparam logic [1:0] ACC_SRC_ALU = 2'd0;
   localparam logic [1:0] ACC_SRC_MEM = 2'd1;
   localparam logic [1:0] ACC_SRC_IMM = 2'd2;

   // Condition codes equal the low three opcode bits of BEQ..BLE.
   localparam logic [2:0] BR_EQ = 3'd0;
   localparam logic [2:0] BR_NE = 3'd1;
   localparam logic [2:0] BR_GT = 3'd2;
   localparam logic [2:0] BR_GE = 3'd3;
   localparam logic [2:0] BR_LT = 3'd4;
   localparam logic [2:0] BR_LE = 3'd5;

   typedef struct packed {
      logic       alu_sub;      // ALU subtracts
      logic       alu_src_imm;  // ALU operand2 is the IR operand
      logic [1:0] acc_src;      // accumulator source select
      logic       wb;           // instruction needs a WRITEBACK cycle
      logic       set_flags;    // WRITEBACK latches Z/N
      logic       mem_rd;       // data read in EXECUTE
      logic       mem_wr;       // data write in EXECUTE
      logic       branch;       // conditional branch
      logic [2:0] br_cond;      // condition code for branch
      logic       jump;         // unconditional jump
      logic       halt;         // HLT
   } ctrl_t;

   function automatic logic branch_taken(input logic [2:0] cond,
                                         input logic       z,
                                         input logic       n);
      case (cond)
         BR_EQ:   branch_taken = z;
         BR_NE:   branch_taken = !z;
         BR_GT:   branch_taken = !z && !n;
         BR_GE:   branch_taken = !n;
         BR_LT:   branch_taken = n;
         BR_LE:   branch_taken = n || z;
         default: branch_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/bip2_decoder.sv
// bip2_decoder: combinational opcode -> control word.
//   i_opcode  in   opcode field of the instruction register
//   o_ctrl    out  decoded control word (ALU op, source selects,
//                  memory strobes, branch/jump/halt, condition code)
// Unlisted opcodes decode to an all-zero word, i.e. NOP.
module bip2_decoder
   import bip2_pkg::*;
(
   input  logic [BIP2_OPC_W-1:0] i_opcode,
   output ctrl_t                 o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_opcode)
         OP_HLT:  o_ctrl.halt = 1'b1;
         OP_STO:  o_ctrl.mem_wr = 1'b1;
         OP_LD: begin
            o_ctrl.mem_rd  = 1'b1;
            o_ctrl.wb      = 1'b1;
            o_ctrl.acc_src = ACC_SRC_MEM;
         end
         OP_LDI: begin
            o_ctrl.wb      = 1'b1;
            o_ctrl.acc_src = ACC_SRC_IMM;
         end
         OP_ADD, OP_SUB: begin
            o_ctrl.mem_rd    = 1'b1;
            o_ctrl.wb        = 1'b1;
            o_ctrl.set_flags = 1'b1;
            o_ctrl.acc_src   = ACC_SRC_ALU;
            o_ctrl.alu_sub   = (i_opcode == OP_SUB);
         end
         OP_ADDI, OP_SUBI: begin
            o_ctrl.wb          = 1'b1;
            o_ctrl.set_flags   = 1'b1;
            o_ctrl.alu_src_imm = 1'b1;
            o_ctrl.acc_src     = ACC_SRC_ALU;
            o_ctrl.alu_sub     = (i_opcode == OP_SUBI);
         end
         OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE: begin
            o_ctrl.branch  = 1'b1;
            o_ctrl.br_cond = i_opcode[2:0];
         end
         OP_JMP:  o_ctrl.jump = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/bip2_control_unit.sv
// bip2_control_unit: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer
// for the BIP-2 datapath. Owns PC, IR and the latched Z/N flags.
//   clk, rst          clock; synchronous active-high reset
//   instr_addr_o/rd_o instruction address (PC) and read strobe
//   instr_data_i      instruction word, valid the cycle after the read
//   data_addr_o       data address (IR operand)
//   data_rd_o/wr_o    data memory read / write strobes
//   operand_o         IR operand (immediate / branch target)
//   alu_operation_o   0 = add, 1 = sub
//   alu_src_imm_o     ALU operand2: 1 = operand_o, 0 = data memory
//   acc_src_o         0 = ALU, 1 = data memory, 2 = operand_o
//   acc_wr_o          accumulator write enable
//   alu_z_i/alu_n_i   ALU zero / negative, latched on ALU writebacks
//   halted_o          high in HALT
// Build option BIP2_MEM_WAIT_EN adds instr_ready_i / data_ready_i; FETCH and
// the data-memory EXECUTE cycles then hold until the matching ready is high.
module bip2_control_unit
   import bip2_pkg::*;
#(
   parameter int ADDR_W = BIP2_ADDR_W,
   parameter int OPC_W  = BIP2_OPC_W
)(
   input  logic                    clk,
   input  logic                    rst,
   output logic [ADDR_W-1:0]       instr_addr_o,
   output logic                    instr_rd_o,
   input  logic [OPC_W+ADDR_W-1:0] instr_data_i,
   output logic [ADDR_W-1:0]       data_addr_o,
   output logic                    data_rd_o,
   output logic                    data_wr_o,
   output logic [ADDR_W-1:0]       operand_o,
   output logic                    alu_operation_o,
   output logic                    alu_src_imm_o,
   output logic [1:0]              acc_src_o,
   output logic                    acc_wr_o,
   input  logic                    alu_z_i,
   input  logic                    alu_n_i,
   output logic                    halted_o
`ifdef BIP2_MEM_WAIT_EN
   ,
   input  logic                    instr_ready_i,
   input  logic                    data_ready_i
`endif
);

   state_t                  r_state;
   logic [ADDR_W-1:0]       r_pc;
   logic [OPC_W+ADDR_W-1:0] r_ir;
   logic                    r_z;
   logic                    r_n;

   ctrl_t             w_ctrl;
   logic [ADDR_W-1:0] w_operand;
   logic              w_instr_rdy;
   logic              w_data_rdy;
   logic              w_data_op;
   logic              w_take_pc;
   logic              w_run;

   assign w_operand = r_ir[ADDR_W-1:0];

   bip2_decoder u_dec (
      .i_opcode (r_ir[ADDR_W +: OPC_W]),
      .o_ctrl   (w_ctrl)
   );

`ifdef BIP2_MEM_WAIT_EN
   assign w_instr_rdy = instr_ready_i;
   assign w_data_rdy  = data_ready_i;
`else
   assign w_instr_rdy = 1'b1;
   assign w_data_rdy  = 1'b1;
`endif

   assign w_data_op = w_ctrl.mem_rd | w_ctrl.mem_wr;
   // Branches look only at the latched flags, never the live ALU outputs.
   assign w_take_pc = w_ctrl.jump |
                      (w_ctrl.branch & branch_taken(w_ctrl.br_cond, r_z, r_n));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FETCH;
         r_pc    <= '0;
         r_ir    <= '0;
         r_z     <= 1'b0;
         r_n     <= 1'b0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (w_instr_rdy) r_state <= ST_DECODE;
            end
            ST_DECODE: begin
               r_ir    <= instr_data_i;
               r_pc    <= r_pc + ADDR_W'(1);
               r_state <= ST_EXECUTE;
            end
            ST_EXECUTE: begin
               if (w_ctrl.halt) begin
                  r_state <= ST_HALT;
               end else if (w_data_op && !w_data_rdy) begin
                  r_state <= ST_EXECUTE;
               end else if (w_ctrl.wb) begin
                  r_state <= ST_WRITEBACK;
               end else begin
                  if (w_take_pc) r_pc <= w_operand;
                  r_state <= ST_FETCH;
               end
            end
            ST_WRITEBACK: begin
               if (w_ctrl.set_flags) begin
                  r_z <= alu_z_i;
                  r_n <= alu_n_i;
               end
               r_state <= ST_FETCH;
            end
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_FETCH;
         endcase
      end
   end

   // Strobes are decoded from the registered state; masking them with rst
   // keeps an interrupted STO/writeback from committing in the reset cycle.
   assign w_run = ~rst;

   assign instr_addr_o    = r_pc;
   assign instr_rd_o      = w_run & (r_state == ST_FETCH);
   assign data_addr_o     = w_operand;
   assign data_rd_o       = w_run & (r_state == ST_EXECUTE) & w_ctrl.mem_rd;
   assign data_wr_o       = w_run & (r_state == ST_EXECUTE) & w_ctrl.mem_wr;
   assign operand_o       = w_operand;
   // Selects follow IR, so they hold steady from EXECUTE through WRITEBACK.
   assign alu_operation_o = w_ctrl.alu_sub;
   assign alu_src_imm_o   = w_ctrl.alu_src_imm;
   assign acc_src_o       = w_ctrl.acc_src;
   assign acc_wr_o        = w_run & (r_state == ST_WRITEBACK);
   assign halted_o        = w_run & (r_state == ST_HALT);

endmodule

// File: tb/tb_bip2_control_unit.sv
// Testbench for bip2_control_unit: surrounding memories and an 11-bit
// add/sub ALU driven by the DUT strobes, checked against an ISA-level model
// (program counter, accumulator, flags, data memory, cycles per instruction).
module tb_bip2_control_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] instr_addr_o;
   logic        instr_rd_o;
   logic [15:0] instr_data_i = '0;
   logic [10:0] data_addr_o;
   logic        data_rd_o;
   logic        data_wr_o;
   logic [10:0] operand_o;
   logic        alu_operation_o;
   logic        alu_src_imm_o;
   logic [1:0]  acc_src_o;
   logic        acc_wr_o;
   logic        alu_z_i = 1'b0;
   logic        alu_n_i = 1'b0;
   logic        halted_o;
   logic        instr_ready_i = 1'b1;
   logic        data_ready_i  = 1'b1;

   always #5 clk = ~clk;

   bip2_control_unit dut (
      .clk             (clk),
      .rst             (rst),
      .instr_addr_o    (instr_addr_o),
      .instr_rd_o      (instr_rd_o),
      .instr_data_i    (instr_data_i),
      .data_addr_o     (data_addr_o),
      .data_rd_o       (data_rd_o),
      .data_wr_o       (data_wr_o),
      .operand_o       (operand_o),
      .alu_operation_o (alu_operation_o),
      .alu_src_imm_o   (alu_src_imm_o),
      .acc_src_o       (acc_src_o),
      .acc_wr_o        (acc_wr_o),
      .alu_z_i         (alu_z_i),
      .alu_n_i         (alu_n_i),
      .halted_o        (halted_o)
`ifdef BIP2_MEM_WAIT_EN
      ,
      .instr_ready_i   (instr_ready_i),
      .data_ready_i    (data_ready_i)
`endif
   );

   // Environment: memories and accumulator datapath
   logic [15:0] imem [0:2047];
   logic [10:0] dmem [0:2047];
   logic [10:0] acc = '0;
   logic        fetch_pend = 1'b0;
   logic [10:0] fetch_addr = '0;
   logic        rd_pend = 1'b0;
   logic [10:0] rd_addr = '0;
   logic [10:0] mem_data = '0;
   int          cyc = 0;
   int          wr_cyc[$];
   logic        wr_sub[$];

   // ISA-level reference state
   logic [10:0] m_pc = '0;
   logic [10:0] m_acc = '0;
   logic        m_z = 1'b0;
   logic        m_n = 1'b0;
   logic [10:0] m_dmem [0:2047];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] a);
      return {op, a};
   endfunction

   task automatic set_dmem(input logic [10:0] a, input logic [10:0] v);
      dmem[a]   = v;
      m_dmem[a] = v;
   endtask

   // One cycle of environment behaviour, evaluated just after the clock edge.
   task automatic eval();
      logic [10:0] op2;
      logic [10:0] res;
      instr_data_i = fetch_pend ? imem[fetch_addr] : 16'($urandom);
      fetch_pend   = instr_rd_o && instr_ready_i;
      fetch_addr   = instr_addr_o;
      mem_data     = rd_pend ? dmem[rd_addr] : 11'($urandom);
      rd_pend      = data_rd_o && data_ready_i;
      rd_addr      = data_addr_o;
      op2 = alu_src_imm_o ? operand_o : mem_data;
      res = alu_operation_o ? acc - op2 : acc + op2;
      alu_z_i = (res == 11'd0);
      alu_n_i = res[10];
      if (data_wr_o && data_ready_i) dmem[data_addr_o] = acc;
      if (acc_wr_o) begin
         wr_cyc.push_back(cyc);
         wr_sub.push_back(alu_operation_o);
         case (acc_src_o)
            2'd0:    acc = res;
            2'd1:    acc = mem_data;
            2'd2:    acc = operand_o;
            default: acc = 'x;
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      eval();
   endtask

   // Two reset cycles; returns 1 time unit into the first cycle after release.
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("reset_strobes", {instr_rd_o, data_rd_o, data_wr_o, acc_wr_o, halted_o}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      fetch_pend = 1'b0;
      rd_pend = 1'b0;
      cyc = 1;
      wr_cyc.delete();
      wr_sub.delete();
      m_pc = '0;
      m_z = 1'b0;
      m_n = 1'b0;
      m_acc = acc;
      #1;
   endtask

   task automatic start();
      do_reset();
      eval();
   endtask

   // Architectural effect of one instruction plus its expected cycle count.
   task automatic model_step(input logic [15:0] iw, output int cpi, output bit halt);
      logic [4:0]  opc;
      logic [10:0] opd;
      logic [10:0] r;
      bit          take;
      opc = iw[15:11];
      opd = iw[10:0];
      halt = 1'b0;
      cpi = 3;
      take = 1'b0;
      r = m_acc;
      m_pc = m_pc + 11'd1;
      case (opc)
         5'h00: halt = 1'b1;
         5'h01: m_dmem[opd] = m_acc;
         5'h02: begin m_acc = m_dmem[opd]; cpi = 4; end
         5'h03: begin m_acc = opd; cpi = 4; end
         5'h04: begin r = m_acc + m_dmem[opd]; cpi = 4; end
         5'h05: begin r = m_acc + opd; cpi = 4; end
         5'h06: begin r = m_acc - m_dmem[opd]; cpi = 4; end
         5'h07: begin r = m_acc - opd; cpi = 4; end
         5'h08: take = m_z;
         5'h09: take = !m_z;
         5'h0A: take = !m_z && !m_n;
         5'h0B: take = !m_n;
         5'h0C: take = m_n;
         5'h0D: take = m_n || m_z;
         5'h0E: take = 1'b1;
         default: ;
      endcase
      if (opc >= 5'h04 && opc <= 5'h07) begin
         m_acc = r;
         m_z = (r == 11'd0);
         m_n = r[10];
      end
      if (take) m_pc = opd;
   endtask

   // Runs one instruction starting in its FETCH cycle and checks it.
   task automatic exec_one(input string tag);
      logic [15:0] iw;
      int          cpi;
      bit          halt;
      int          n;
      check({tag, "_fetch_rd"}, instr_rd_o, 1);
      check({tag, "_fetch_addr"}, instr_addr_o, m_pc);
      iw = imem[m_pc];
      model_step(iw, cpi, halt);
      n = 0;
      do begin
         tick();
         n++;
      end while (!instr_rd_o && !halted_o && n < 12);
      check({tag, "_cycles"}, n, halt ? 3 : cpi);
      check({tag, "_halted"}, halted_o, halt);
      check({tag, "_acc"}, acc, m_acc);
      if (iw[15:11] == 5'h01) check({tag, "_sto_mem"}, dmem[iw[10:0]], m_dmem[iw[10:0]]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int iw, dw, rdc, drc, awc;
      for (int i = 0; i < 2048; i++) begin
         imem[i] = ins(5'h0F, 11'd0);
         set_dmem(11'(i), 11'd0);
      end

      // Reset state and LDI 5; ADDI 3; SUBI 8; BEQ 0x100
      imem[0] = ins(5'h03, 11'd5);
      imem[1] = ins(5'h05, 11'd3);
      imem[2] = ins(5'h07, 11'd8);
      imem[3] = ins(5'h08, 11'h100);
      start();
      check("rst_instr_addr", instr_addr_o, 0);
      check("rst_instr_rd", instr_rd_o, 1);
      check("rst_strobes", {data_rd_o, data_wr_o, acc_wr_o, halted_o}, 0);
      check("rst_selects", {alu_operation_o, alu_src_imm_o, acc_src_o}, 0);
      check("rst_addr_operand", {data_addr_o, operand_o}, 0);
      exec_one("ldi");
      exec_one("addi");
      exec_one("subi");
      check("wb_count", wr_cyc.size(), 3);
      check("wb_cycle0", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 4);
      check("wb_cycle1", (wr_cyc.size() > 1) ? wr_cyc[1] : -1, 8);
      check("wb_cycle2", (wr_cyc.size() > 2) ? wr_cyc[2] : -1, 12);
      check("wb_sub_ldi", (wr_sub.size() > 0) ? wr_sub[0] : 1'bx, 0);
      check("wb_sub_addi", (wr_sub.size() > 1) ? wr_sub[1] : 1'bx, 0);
      check("wb_sub_subi", (wr_sub.size() > 2) ? wr_sub[2] : 1'bx, 1);
      exec_one("beq");
      check("beq_z_set", instr_addr_o, 11'h100);

      // Negative result: BLT taken, BGE falls through
      imem[0] = ins(5'h03, 11'd0);
      imem[1] = ins(5'h07, 11'd1);
      imem[2] = ins(5'h0C, 11'h040);
      start();
      exec_one("ldi0");
      exec_one("subi1");
      check("acc_neg", acc, 11'h7FF);
      exec_one("blt");
      check("blt_target", instr_addr_o, 11'h040);
      imem[2] = ins(5'h0B, 11'h040);
      start();
      exec_one("ldi0b");
      exec_one("subi1b");
      exec_one("bge");
      check("bge_fallthrough", instr_addr_o, 11'h003);

      // PC wrap from 0x7FF
      imem[0] = ins(5'h0E, 11'h7FF);
      imem[11'h7FF] = ins(5'h0F, 11'd0);
      start();
      exec_one("jmp");
      check("jmp_target", instr_addr_o, 11'h7FF);
      exec_one("nop_7ff");
      check("pc_wrap", instr_addr_o, 11'h000);

      // Reset during STO EXECUTE must not write memory
      imem[0] = ins(5'h03, 11'h02A);
      imem[1] = ins(5'h01, 11'h055);
      set_dmem(11'h055, 11'h123);
      start();
      exec_one("abort_ldi");
      tick();
      @(posedge clk);
      #1;
      check("abort_pre_wr", data_wr_o, 1);
      rst = 1'b1;
      #1;
      cyc++;
      eval();
      check("abort_no_wr", data_wr_o, 0);
      check("abort_mem", dmem[11'h055], 11'h123);
      start();
      check("abort_refetch", instr_addr_o, 0);

      // HALT holds with no strobes until reset
      imem[0] = ins(5'h00, 11'h3C3);
      start();
      exec_one("hlt");
      for (int i = 0; i < 20; i++) begin
         tick();
         check("halt_hold", {halted_o, instr_rd_o, data_rd_o, data_wr_o, acc_wr_o}, 5'b10000);
      end
      start();
      check("halt_exit_halted", halted_o, 0);
      check("halt_exit_addr", instr_addr_o, 0);
      check("halt_exit_rd", instr_rd_o, 1);

`ifdef BIP2_MEM_WAIT_EN
      // Memory wait states: fetch stalled 3 cycles, LD data stalled 2 cycles
      imem[0] = ins(5'h02, 11'h010);
      imem[1] = ins(5'h00, 11'h000);
      set_dmem(11'h010, 11'h2AB);
      do_reset();
      iw = 0; dw = 0; rdc = 0; drc = 0; awc = 0;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         instr_ready_i = 1'b1;
         data_ready_i = 1'b1;
         if (instr_rd_o) begin instr_ready_i = (iw >= 3); iw++; rdc++; end
         if (data_rd_o) begin data_ready_i = (dw >= 2); dw++; drc++; end
         eval();
         if (acc_wr_o) awc++;
      end
      instr_ready_i = 1'b1;
      data_ready_i = 1'b1;
      check("wait_instr_rd_cycles", rdc, 4);
      check("wait_data_rd_cycles", drc, 3);
      check("wait_acc_wr_pulses", awc, 1);
      check("wait_ld_acc", acc, 11'h2AB);
      tick();
      check("wait_next_fetch", instr_addr_o, 11'h001);
`endif

      // Random programs against the ISA model
      for (int i = 0; i < 2048; i++) begin
         logic [4:0] op;
         op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31))
                                          : 5'($urandom_range(1, 15));
         imem[i] = ins(op, 11'($urandom));
         set_dmem(11'(i), 11'($urandom));
      end
      start();
      for (int k = 0; k < 300; k++) exec_one("rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
